// File: rtl/score_counter.sv
// Two-digit BCD score with saturation at 0 / MAX_SCORE and a time-multiplexed 7-segment display driver.
// Score updates one cycle after an input rising edge; inputs are edge-sensitive, so no backpressure exists.
module score_counter #(
  parameter int MAX_SCORE          = 99,
  parameter int MUX_PERIOD         = 5,
  parameter int BLANK_LEADING_ZERO = 1
) (
  input  logic       clk_1khz,
  input  logic       rst_i,
  input  logic       count_up,
  input  logic       count_down,
  output logic [3:0] ones_o,
  output logic [3:0] tens_o,
  output logic [6:0] seg_o,
  output logic [1:0] digit_sel_o,
  output logic       limit_o
);

  localparam int             MCW       = (MUX_PERIOD > 1) ? $clog2(MUX_PERIOD) : 1;
  localparam logic [MCW-1:0] MUX_LAST  = MCW'(MUX_PERIOD - 1);
  localparam logic [3:0]     MAX_TENS  = 4'(MAX_SCORE / 10);
  localparam logic [3:0]     MAX_ONES  = 4'(MAX_SCORE % 10);

  logic [3:0]     ones_q, ones_d;
  logic [3:0]     tens_q, tens_d;
  logic           prev_up_q, prev_dn_q;
  logic [MCW-1:0] mux_cnt_q, mux_cnt_d;
  logic [1:0]     sel_q, sel_d;

  logic       up_evt, dn_evt;
  logic       at_max, at_zero;
  logic [3:0] digit;

  assign up_evt  = count_up & ~prev_up_q;
  assign dn_evt  = count_down & ~prev_dn_q;
  assign at_max  = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
  assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

  // Simultaneous up and down events cancel; each saturates at its own limit.
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (up_evt && !dn_evt && !at_max) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dn_evt && !up_evt && !at_zero) begin
      if (ones_q == 4'd0) begin
        ones_d = 4'd9;
        tens_d = tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_comb begin
    mux_cnt_d = mux_cnt_q + 1'b1;
    sel_d     = sel_q;
    if (mux_cnt_q == MUX_LAST) begin
      mux_cnt_d = '0;
      sel_d     = {sel_q[0], sel_q[1]};
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (rst_i) begin
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      prev_up_q <= 1'b0;
      prev_dn_q <= 1'b0;
      mux_cnt_q <= '0;
      sel_q     <= 2'b01;
    end else begin
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      prev_up_q <= count_up;
      prev_dn_q <= count_down;
      mux_cnt_q <= mux_cnt_d;
      sel_q     <= sel_d;
    end
  end

  assign digit = sel_q[1] ? tens_q : ones_q;

  always_comb begin
    case (digit)
      4'd0:    seg_o = 7'h3F;
      4'd1:    seg_o = 7'h06;
      4'd2:    seg_o = 7'h5B;
      4'd3:    seg_o = 7'h4F;
      4'd4:    seg_o = 7'h66;
      4'd5:    seg_o = 7'h6D;
      4'd6:    seg_o = 7'h7D;
      4'd7:    seg_o = 7'h07;
      4'd8:    seg_o = 7'h7F;
      4'd9:    seg_o = 7'h6F;
      default: seg_o = 7'h00;
    endcase
    if (sel_q[1] && (BLANK_LEADING_ZERO != 0) && (tens_q == 4'd0)) begin
      seg_o = 7'h00;
    end
  end

  assign ones_o      = ones_q;
  assign tens_o      = tens_q;
  assign digit_sel_o = sel_q;
  assign limit_o     = at_max | at_zero;

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: integer score model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_score_counter;

  localparam int MAX = 99;
  localparam int P   = 5;
  localparam int BLZ = 1;

  logic       clk = 1'b0;
  logic       rst, up, dn;
  logic [3:0] ones_o, tens_o;
  logic [6:0] seg_o;
  logic [1:0] digit_sel_o;
  logic       limit_o;

  int n_chk  = 0;
  int n_fail = 0;

  score_counter #(.MAX_SCORE(MAX), .MUX_PERIOD(P), .BLANK_LEADING_ZERO(BLZ)) dut (
    .clk_1khz    (clk),
    .rst_i       (rst),
    .count_up    (up),
    .count_down  (dn),
    .ones_o      (ones_o),
    .tens_o      (tens_o),
    .seg_o       (seg_o),
    .digit_sel_o (digit_sel_o),
    .limit_o     (limit_o)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the score as a plain integer, the mux slot from cycles elapsed since reset.
  int ms      = 0;
  int k       = 0;
  bit pu      = 0;
  bit pd      = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      ms = 0; pu = 0; pd = 0; k = 0; m_valid = 1;
    end else if (m_valid) begin
      if (up && !pu && !(dn && !pd)) begin
        if (ms < MAX) ms++;
      end else if (dn && !pd && !(up && !pu)) begin
        if (ms > 0) ms--;
      end
      pu = up; pd = dn; k++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      int e_sel, e_dig;
      logic [6:0] e_seg;
      e_sel = ((k / P) % 2 == 1) ? 2 : 1;
      e_dig = (e_sel == 2) ? ms / 10 : ms % 10;
      e_seg = (e_sel == 2 && BLZ != 0 && ms / 10 == 0) ? 7'h00 : glyph[e_dig];
      chk("ones", ones_o, ms % 10);
      chk("tens", tens_o, ms / 10);
      chk("limit", limit_o, (ms == 0 || ms == MAX) ? 1 : 0);
      chk("digit_sel", digit_sel_o, e_sel);
      chk("seg", seg_o, e_seg);
    end
  end

  function automatic int score();
    return int'(tens_o) * 10 + int'(ones_o);
  endfunction

  // All tasks are entered and left on a falling edge.
  task automatic pulse_up();
    up = 1; @(negedge clk);
    up = 0; repeat (2) @(negedge clk);
  endtask

  task automatic pulse_dn();
    dn = 1; @(negedge clk);
    dn = 0; repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    bit found;
    rst = 1; up = 0; dn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ones", ones_o, 0);
    chk("rst_tens", tens_o, 0);
    chk("rst_limit", limit_o, 1);
    chk("rst_sel", digit_sel_o, 2'b01);
    chk("rst_seg", seg_o, 7'h3F);
    rst = 0;
    repeat (5) @(negedge clk);
    chk("blank_sel", digit_sel_o, 2'b10);
    chk("blank_seg", seg_o, 7'h00);

    repeat (10) pulse_up();
    chk("carry_tens", tens_o, 1);
    chk("carry_ones", ones_o, 0);
    chk("carry_limit", limit_o, 0);
    found = 0;
    for (int i = 0; i < 2 * P + 2 && !found; i++) begin
      if (digit_sel_o == 2'b10) found = 1;
      else @(negedge clk);
    end
    chk("tens_slot_seen", found, 1);
    chk("tens_slot_seg", seg_o, 7'h06);

    up = 1; repeat (2100) @(negedge clk);
    up = 0; @(negedge clk);
    chk("hold_once", score(), 11);

    do_reset();
    repeat (10) pulse_up();
    pulse_dn();
    chk("borrow_tens", tens_o, 0);
    chk("borrow_ones", ones_o, 9);
    repeat (9) pulse_dn();
    chk("floor_score", score(), 0);
    chk("floor_limit", limit_o, 1);
    pulse_dn();
    chk("floor_hold", score(), 0);

    do_reset();
    repeat (105) pulse_up();
    chk("ceil_tens", tens_o, 9);
    chk("ceil_ones", ones_o, 9);
    chk("ceil_limit", limit_o, 1);
    pulse_dn();
    chk("ceil_dn", score(), 98);
    chk("ceil_dn_limit", limit_o, 0);

    do_reset();
    repeat (5) pulse_up();
    up = 1; dn = 1; repeat (3) @(negedge clk);
    chk("simul_keep", score(), 5);
    up = 0; dn = 0; @(negedge clk);
    up = 1; @(negedge clk);
    chk("simul_then_up", score(), 6);
    up = 0; @(negedge clk);

    do_reset();
    repeat (6) pulse_up();
    up = 1; @(negedge clk);
    chk("midhold_pre", score(), 7);
    rst = 1; @(negedge clk);
    chk("midhold_rst", score(), 0);
    rst = 0; @(negedge clk);
    chk("midhold_edge", score(), 1);
    repeat (5) @(negedge clk);
    chk("midhold_once", score(), 1);
    up = 0; @(negedge clk);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) up = ~up;
      if ($urandom_range(0, 4) == 0) dn = ~dn;
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 0; up = 0; dn = 0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/score_counter.md
Name: score_counter

Overview:
- Downstream consumer of the pushbutton processor's count_up / count_down outputs.
- Holds a two-digit BCD score, saturating at 0 and MAX_SCORE.
- Drives a time-multiplexed two-digit 7-segment display.
- Runs in the same 1 kHz clock domain as the pushbutton processor; it is the score/display stage of the scoreboard.

Parameters:
- MAX_SCORE, 99, upper saturation limit; decimal, range 1..99.
- MUX_PERIOD, 5, clock cycles each digit is enabled (5 ms at 1 kHz); minimum 1.
- BLANK_LEADING_ZERO, 1, when 1 the tens digit is blanked while the tens value is 0.

Ports:
- clk_1khz  input  1  system clock, 1 kHz.
- rst_i  input  1  reset: synchronous, active-high.
- count_up  input  1  increment request from the pushbutton processor; level, acted on at its rising edge.
- count_down  input  1  decrement request from the pushbutton processor; level, acted on at its rising edge.
- ones_o  output  4  BCD ones digit of the score.
- tens_o  output  4  BCD tens digit of the score.
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active-high, for the currently selected digit.
- digit_sel_o  output  2  one-hot digit enable: 2'b01 = ones, 2'b10 = tens; active-high.
- limit_o  output  1  1 while the score equals 0 or MAX_SCORE.

Behaviour:
- Reset (rst_i = 1 at a clock edge):
  - score = 0, so ones_o = 0 and tens_o = 0.
  - Both input-history registers cleared to 0.
  - Mux counter = 0; digit_sel_o = 2'b01.
  - seg_o = 7'b0111111 (glyph "0"); limit_o = 1.
  - rst_i has priority over every other event. Reset mid-hold: an input still high after reset is released is seen as a new rising edge (history is 0).
- Edge detection:
  - Register each input once (prev). up_evt = count_up & ~prev_up; down_evt likewise.
  - An input held high produces exactly one event.
  - Events are applied on the same edge they are detected, so ones_o / tens_o update 1 cycle after the input rises.
- Score update, BCD arithmetic, no binary conversion:
  - up_evt only, score < MAX_SCORE:
    - ones == 9 -> ones = 0 and tens += 1.
    - otherwise ones += 1.
  - up_evt only, score == MAX_SCORE: no change (saturate).
  - down_evt only, score > 0:
    - ones == 0 -> ones = 9 and tens -= 1.
    - otherwise ones -= 1.
  - down_evt only, score == 0: no change.
  - up_evt and down_evt on the same edge: both ignored, score unchanged.
  - ones_o and tens_o never hold values above 9.
- limit_o:
  - Combinational from the registered score.
  - Valid in the same cycle the score changes.
- Display mux:
  - A counter counts 0..MUX_PERIOD-1.
  - On wrap, digit_sel_o toggles between 2'b01 and 2'b10.
  - A full display frame is 2*MUX_PERIOD cycles.
  - The mux is free-running and unaffected by score events.
  - digit_sel_o is always exactly one-hot and never 2'b00 or 2'b11.
- Segment decode:
  - Combinational from the selected digit: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, {g..a}).
  - Tens selected, BLANK_LEADING_ZERO = 1, tens == 0 -> seg_o = 7'b0000000; digit_sel_o still asserts 2'b10.
  - Any undefined code decodes to 7'b0000000 (defensive; unreachable).

Test Plan:
- Reset:
  - Hold rst_i = 1 for 2 cycles, release -> ones_o = 0, tens_o = 0, limit_o = 1, digit_sel_o = 2'b01, seg_o = 7'h3F.
  - After 5 cycles digit_sel_o = 2'b10 and seg_o = 7'h00 (blanked).
- Increment carry:
  - Apply 10 separate count_up pulses, each 1 ms high and 2 ms low -> tens_o = 1, ones_o = 0, limit_o = 0.
  - During the tens slot seg_o = 7'h06.
  - A single count_up held high for 2100 cycles -> exactly one increment (score 11).
- Decrement borrow and floor:
  - From score 10, one count_down -> tens_o = 0, ones_o = 9.
  - 9 more count_down pulses -> score 0, limit_o = 1.
  - An extra count_down -> score stays 0.
- Ceiling:
  - Pulse count_up 105 times from 0 -> score saturates at 99 (tens_o = 9, ones_o = 9), limit_o = 1.
  - Then one count_down -> 98, limit_o = 0.
- Simultaneous events:
  - Raise count_up and count_down on the same edge at score 5 -> score stays 5.
  - Drop both, then raise count_up alone -> score 6.
- Reset mid-hold:
  - At score 7 with count_up held high, pulse rst_i for 1 cycle -> score 0.
  - With count_up still high after release -> score 1 on the next edge, then no further change.
